icmp_echo_tx: RTL
=================

# icmp_echo_tx

Parametrised ICMP echo-reply transmitter between the ICMP request parser FIFO and the Ethernet MAC TX port. It accepts one parsed echo request with a variable-length payload and computes the IPv4 header and ICMP checksums in a multi-cycle pass. It then streams the reply frame MSB-first as multi-byte beats under a per-beat valid/ack handshake with backpressure.

## Interface
Parameters:
- `BEAT_BYTES`, 1: bytes per output beat. Legal values: 1, 2, 4, 8.
- `MAX_PAYLOAD`, 64: maximum ICMP data bytes stored and echoed.
- `LEN_W`, $clog2(MAX_PAYLOAD+1): width of the payload length fields.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `hw_addr_i` in 48: our MAC address. Sampled at request accept.
- `ip_addr_i` in 32: our IPv4 address. Sampled at request accept.
- `req_src_mac_i` in 48: requester MAC address.
- `req_src_ip_i` in 32: requester IP address.
- `req_ip_id_i` in 16: IP identification field, echoed.
- `req_icmp_id_i` in 16: ICMP identifier, echoed.
- `req_icmp_seq_i` in 16: ICMP sequence number, echoed.
- `req_payload_i` in 8*MAX_PAYLOAD: payload bytes. Byte 0 is in the top 8 bits.
- `req_len_i` in LEN_W+1: payload length in bytes.
- `req_valid_i` in 1: a request is present.
- `req_ack_o` out 1: 1-cycle pop strobe to the request FIFO.
- `mac_data_o` out 8*BEAT_BYTES: output beat. The first byte of the beat is in the top lane.
- `mac_keep_o` out BEAT_BYTES: lane-valid mask. The MSB of the mask corresponds to the top lane.
- `mac_last_o` out 1: marks the final beat of the frame.
- `mac_valid_o` out 1: beat valid.
- `mac_ack_i` in 1: the MAC consumed the beat.
- `tx_cnt_o` out 16: count of frames sent. Saturates at 0xFFFF.
- `drop_cnt_o` out 16: count of requests dropped. Saturates at 0xFFFF.

## Operation
- `req_ack_o` = (state==IDLE) && `req_valid_i`. When it is high, all `req_*_i` inputs, `hw_addr_i` and `ip_addr_i` are latched.
- A request with `req_len_i` > MAX_PAYLOAD is dropped:
  - it is acked;
  - `drop_cnt_o` increments;
  - the block stays in IDLE, and no frame is sent.
- States:
  - IDLE → CSUM on a valid accept.
  - CSUM adds one 16-bit payload word per cycle into a 17-bit accumulator with end-around carry. It runs for max(1, ceil(len/2)) cycles. The seed is type/code 0x0000 + id + seq.
  - For an odd len, the final byte is padded with a low zero byte.
  - CSUM → FOLD. FOLD performs the final carry fold and inverts the ICMP sum. The IP header checksum is computed combinationally from the latched fields.
  - FOLD → SEND. SEND streams beats.
  - SEND → IDLE on an accepted beat with `mac_last_o` set.
- Reply header values:
  - dst MAC = requester MAC; src MAC = our MAC; ethertype = 0x0800.
  - IP version 4, IHL 5, TOS 0, total length = 28+len.
  - IP id echoed; flags and fragment offset 0; TTL 0x40; protocol 0x01.
  - IP src = our IP; IP dst = requester IP.
  - ICMP type 0, code 0; ICMP id, seq and payload echoed.
- Frame length F = 42+len bytes. Beats per frame = ceil(F/BEAT_BYTES).
  - Non-last beats have all keep bits set.
  - The last beat has keep bits set for the top (F mod BEAT_BYTES, or BEAT_BYTES if 0) lanes. Unused lanes carry 0x00.
- `tx_cnt_o` increments on the accepted last beat.

## Timing
- Reset values:
  - `mac_valid_o` = 0, `mac_last_o` = 0, `mac_keep_o` = 0, `mac_data_o` = 0.
  - `req_ack_o` = 0, both counters = 0, state = IDLE.
- A request accepted at cycle T:
  - CSUM occupies T+1 .. T+N, where N = max(1, ceil(len/2)).
  - FOLD is at T+N+1.
  - `mac_valid_o` first rises at T+N+2.
- While `mac_valid_o`=1 and `mac_ack_i`=0, `mac_data_o`, `mac_keep_o` and `mac_last_o` hold stable.
- A beat advances only on `mac_valid_o` && `mac_ack_i`.
- `mac_valid_o` stays high between beats. With `mac_ack_i` held high, one beat is sent per cycle.
- `mac_valid_o` falls in the cycle after the last beat is accepted.
- `req_ack_o` is never high outside IDLE. The earliest next accept is the cycle after `mac_valid_o` falls.
- `rst` mid-frame: outputs take their reset values on the next edge, and the frame is abandoned, not resumed. The request already popped is lost and is not counted.

## Configuration
- `ICMP_TX_PAD_EN` defined:
  - when F < 60, zero bytes are appended so the frame is 60 bytes; the beat count and last-beat keep are based on 60;
  - the IP total length and checksums are unchanged.
- `ICMP_TX_PAD_EN` undefined: the frame is exactly F bytes.

## Test plan
- BEAT_BYTES=1, len=0, id=0x0001, seq=0x0001, `mac_ack_i`=1 → 42 bytes sent (60 with `ICMP_TX_PAD_EN`), ICMP checksum 0xFFFD, IP checksum verifies to 0xFFFF, `tx_cnt_o`=1.
- BEAT_BYTES=1, len=1, payload 0xAB, id=0, seq=0 → ICMP checksum 0x54FF, frame 43 bytes, final byte 0xAB.
- BEAT_BYTES=4, len=0, no padding → 11 beats, last beat `mac_keep_o`=4'b1100 with `mac_last_o`=1, lanes [15:0] = 0x0000.
- BEAT_BYTES=2, len=32, `mac_ack_i` toggling 1-0-1-0 → beats remain stable during stalls, 37 beats in order, `mac_valid_o` first rises at T+18.
- len=MAX_PAYLOAD+1 → `req_ack_o` pulses, `drop_cnt_o`=1, `mac_valid_o` stays 0.
- `rst` asserted for 1 cycle on beat 5 of a frame → `mac_valid_o`=0 the next cycle, counters 0, then a new request produces a complete, correct frame.

Source files
------------

// File: rtl/icmp_echo_tx.sv
// ICMP echo-reply transmitter: latch request, sum ICMP words, fold, then stream the reply MSB-first.
// Optional ICMP_TX_PAD_EN appends zero bytes so short frames reach 60 bytes.
module icmp_echo_tx #(
  parameter int BEAT_BYTES  = 1,
  parameter int MAX_PAYLOAD = 64,
  parameter int LEN_W       = $clog2(MAX_PAYLOAD+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [47:0]              hw_addr_i,
  input  logic [31:0]              ip_addr_i,
  input  logic [47:0]              req_src_mac_i,
  input  logic [31:0]              req_src_ip_i,
  input  logic [15:0]              req_ip_id_i,
  input  logic [15:0]              req_icmp_id_i,
  input  logic [15:0]              req_icmp_seq_i,
  input  logic [8*MAX_PAYLOAD-1:0] req_payload_i,
  input  logic [LEN_W:0]           req_len_i,
  input  logic                     req_valid_i,
  output logic                     req_ack_o,
  output logic [8*BEAT_BYTES-1:0]  mac_data_o,
  output logic [BEAT_BYTES-1:0]    mac_keep_o,
  output logic                     mac_last_o,
  output logic                     mac_valid_o,
  input  logic                     mac_ack_i,
  output logic [15:0]              tx_cnt_o,
  output logic [15:0]              drop_cnt_o
);
  localparam int IDX_W     = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int HDR_BYTES = 42;

  typedef enum logic [1:0] {IDLE, CSUM, FOLD, SEND} state_t;
  state_t state_q, state_d;

  logic [47:0]              dst_mac_q, src_mac_q;
  logic [31:0]              our_ip_q, dst_ip_q;
  logic [15:0]              ip_id_q, icmp_id_q, icmp_seq_q;
  logic [8*MAX_PAYLOAD-1:0] payload_q;
  logic [LEN_W:0]           len_q;
  logic [16:0]              acc_q, acc_d, fold1;
  logic [15:0]              icmp_csum_q, icmp_csum_d;
  logic [15:0]              word_q, word_d, beat_q, beat_d;
  logic [15:0]              tx_cnt_q, drop_cnt_q;
  logic                     accept, drop, tx_fire, csum_last;
  logic [15:0]              cs_word, tot_len, ip_csum;
  logic [19:0]              ip_sum;
  logic [16:0]              ip_f1;
  logic [8*HDR_BYTES-1:0]   hdr;
  logic [7:0]               hdr_b [HDR_BYTES];
  logic [7:0]               pay_b [MAX_PAYLOAD];
  int                       hi_i, lo_i, flen, bidx, pidx;

  for (genvar i = 0; i < MAX_PAYLOAD; i++) begin : g_pay
    assign pay_b[i] = payload_q[8*(MAX_PAYLOAD-1-i) +: 8];
  end

  always_comb begin
    req_ack_o = (state_q == IDLE) && req_valid_i && !rst;
    accept    = req_ack_o;
    drop      = accept && (int'(req_len_i) > MAX_PAYLOAD);
  end

  // One 16-bit word per CSUM cycle; bytes past len read as zero (odd-length pad).
  always_comb begin
    hi_i      = 2 * int'(word_q);
    lo_i      = hi_i + 1;
    cs_word   = 16'h0000;
    if (hi_i < int'(len_q)) cs_word[15:8] = pay_b[hi_i[IDX_W-1:0]];
    if (lo_i < int'(len_q)) cs_word[7:0]  = pay_b[lo_i[IDX_W-1:0]];
    csum_last = (hi_i + 2 >= int'(len_q));
  end

  always_comb begin
    tot_len = 16'd28 + {{(15-LEN_W){1'b0}}, len_q};
    ip_sum  = 20'h04500 + {4'h0, tot_len} + {4'h0, ip_id_q} + 20'h04001
            + {4'h0, our_ip_q[31:16]} + {4'h0, our_ip_q[15:0]}
            + {4'h0, dst_ip_q[31:16]} + {4'h0, dst_ip_q[15:0]};
    ip_f1   = {1'b0, ip_sum[15:0]} + {13'h0000, ip_sum[19:16]};
    ip_csum = ~(ip_f1[15:0] + {15'h0000, ip_f1[16]});
    hdr = {dst_mac_q, src_mac_q, 16'h0800, 8'h45, 8'h00, tot_len, ip_id_q, 16'h0000,
           8'h40, 8'h01, ip_csum, our_ip_q, dst_ip_q, 8'h00, 8'h00, icmp_csum_q,
           icmp_id_q, icmp_seq_q};
    for (int i = 0; i < HDR_BYTES; i++) hdr_b[i] = hdr[8*(HDR_BYTES-1-i) +: 8];
    flen = HDR_BYTES + int'(len_q);
`ifdef ICMP_TX_PAD_EN
    if (flen < 60) flen = 60;
`else
    flen = flen + 0;
`endif
  end

  always_comb begin
    mac_valid_o = (state_q == SEND);
    mac_data_o  = '0;
    mac_keep_o  = '0;
    mac_last_o  = 1'b0;
    bidx        = 0;
    pidx        = 0;
    if (state_q == SEND) begin
      mac_last_o = ((int'(beat_q) + 1) * BEAT_BYTES >= flen);
      for (int l = 0; l < BEAT_BYTES; l++) begin
        bidx = int'(beat_q) * BEAT_BYTES + l;
        pidx = bidx - HDR_BYTES;
        if (bidx < flen) begin
          mac_keep_o[BEAT_BYTES-1-l] = 1'b1;
          if (bidx < HDR_BYTES)
            mac_data_o[8*(BEAT_BYTES-1-l) +: 8] = hdr_b[bidx[5:0]];
          else if (pidx < int'(len_q))
            mac_data_o[8*(BEAT_BYTES-1-l) +: 8] = pay_b[pidx[IDX_W-1:0]];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    word_d      = word_q;
    beat_d      = beat_q;
    icmp_csum_d = icmp_csum_q;
    tx_fire     = 1'b0;
    fold1       = {1'b0, acc_q[15:0]} + {16'h0000, acc_q[16]};
    case (state_q)
      IDLE: if (accept && !drop) begin
        state_d = CSUM;
        acc_d   = {1'b0, req_icmp_id_i} + {1'b0, req_icmp_seq_i};
        word_d  = 16'h0000;
      end
      CSUM: begin
        acc_d  = {1'b0, acc_q[15:0]} + {16'h0000, acc_q[16]} + {1'b0, cs_word};
        word_d = word_q + 16'd1;
        if (csum_last) state_d = FOLD;
      end
      FOLD: begin
        icmp_csum_d = ~(fold1[15:0] + {15'h0000, fold1[16]});
        beat_d      = 16'h0000;
        state_d     = SEND;
      end
      SEND: if (mac_ack_i) begin
        if (mac_last_o) begin
          state_d = IDLE;
          tx_fire = 1'b1;
        end else begin
          beat_d = beat_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      word_q      <= '0;
      beat_q      <= '0;
      icmp_csum_q <= '0;
      tx_cnt_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      word_q      <= word_d;
      beat_q      <= beat_d;
      icmp_csum_q <= icmp_csum_d;
      if (tx_fire && tx_cnt_q != 16'hFFFF) tx_cnt_q <= tx_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !drop) begin
      dst_mac_q  <= req_src_mac_i;
      src_mac_q  <= hw_addr_i;
      our_ip_q   <= ip_addr_i;
      dst_ip_q   <= req_src_ip_i;
      ip_id_q    <= req_ip_id_i;
      icmp_id_q  <= req_icmp_id_i;
      icmp_seq_q <= req_icmp_seq_i;
      payload_q  <= req_payload_i;
      len_q      <= req_len_i;
    end
  end

  assign tx_cnt_o   = tx_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
endmodule
